// File: rtl/cnn_layer_sequencer.sv
// Sequencer for one conv->ReLU->maxpool layer: sliding window load, conv launch, max-pool, emit.
// Optional fused ReLU on conv results when CNN_SEQ_RELU_EN is defined.
module cnn_layer_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned IN_CH     = 4,
  parameter int unsigned OUT_CH    = 8,
  parameter int unsigned KSIZE     = 5,
  parameter int unsigned POOL      = 5,
  parameter int unsigned FRAME_LEN = 500,
  parameter int unsigned PAD_TAIL  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [IN_CH*DATA_W-1:0]         in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [IN_CH*KSIZE*DATA_W-1:0]   win_data,
  output logic                            conv_start,
  input  logic [OUT_CH*DATA_W-1:0]        conv_res,
  input  logic                            conv_valid,
  output logic [OUT_CH*DATA_W-1:0]        out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned TOTAL   = FRAME_LEN + PAD_TAIL;
  localparam int unsigned NCONV   = TOTAL - KSIZE + 1;
  localparam int unsigned NUM_OUT = NCONV / POOL;
  localparam int unsigned SMP_W   = $clog2(TOTAL + 1);
  localparam int unsigned OUT_W   = $clog2(NUM_OUT + 1);
  localparam int unsigned POOL_W  = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned WIN_W   = IN_CH * KSIZE * DATA_W;
  localparam int unsigned RES_W   = OUT_CH * DATA_W;

  localparam logic [SMP_W-1:0]  FRAME_LEN_C = SMP_W'(FRAME_LEN);
  localparam logic [SMP_W-1:0]  KSIZE_C     = SMP_W'(KSIZE);
  localparam logic [POOL_W-1:0] POOL_LAST_C = POOL_W'(POOL - 1);
  localparam logic [OUT_W-1:0]  OUT_LAST_C  = OUT_W'(NUM_OUT - 1);

  if (((NCONV % POOL) != 0) || (KSIZE > FRAME_LEN)) begin : g_bad_cfg
    $error("cnn_layer_sequencer: NCONV must be a multiple of POOL and KSIZE <= FRAME_LEN");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CONV = 3'd2,
    S_WAIT = 3'd3,
    S_EMIT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic [RES_W-1:0]    max_q, max_d;
  logic [SMP_W-1:0]    smp_cnt_q, smp_cnt_d;
  logic [POOL_W-1:0]   pool_cnt_q, pool_cnt_d;
  logic [OUT_W-1:0]    out_cnt_q, out_cnt_d;
  logic                done_q, done_d;

  logic                pad_phase_c;
  logic                shift_c;
  logic [SMP_W-1:0]    smp_next_c;

  // Past the real samples the window is fed zeros without a handshake.
  assign pad_phase_c = (smp_cnt_q >= FRAME_LEN_C);
  assign shift_c     = (state_q == S_LOAD) && (pad_phase_c || in_valid);
  assign smp_next_c  = smp_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: if (shift_c && (smp_next_c >= KSIZE_C)) state_d = S_CONV;
      S_CONV: state_d = S_WAIT;
      S_WAIT: if (conv_valid) state_d = (pool_cnt_q == POOL_LAST_C) ? S_EMIT : S_LOAD;
      S_EMIT: if (out_ready) state_d = (out_cnt_q == OUT_LAST_C) ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == S_LOAD) && !pad_phase_c;
    conv_start = (state_q == S_CONV);
    out_valid  = (state_q == S_EMIT);
    out_data   = max_q;
    win_data   = win_q;
    busy       = (state_q != S_IDLE) || done_q;
    done       = done_q;
  end

  // Window shift, pooling and frame counters.
  always_comb begin
    logic [DATA_W-1:0] r;
    win_d      = win_q;
    max_d      = max_q;
    smp_cnt_d  = smp_cnt_q;
    pool_cnt_d = pool_cnt_q;
    out_cnt_d  = out_cnt_q;
    done_d     = 1'b0;
    r          = '0;

    if ((state_q == S_IDLE) && start) begin
      win_d      = '0;
      smp_cnt_d  = '0;
      pool_cnt_d = '0;
      out_cnt_d  = '0;
    end

    if (shift_c) begin
      for (int unsigned c = 0; c < IN_CH; c++) begin
        for (int unsigned k = 1; k < KSIZE; k++) begin
          win_d[(c*KSIZE+k)*DATA_W +: DATA_W] = win_q[(c*KSIZE+k-1)*DATA_W +: DATA_W];
        end
        win_d[(c*KSIZE)*DATA_W +: DATA_W] = pad_phase_c ? '0 : in_data[c*DATA_W +: DATA_W];
      end
      smp_cnt_d = smp_next_c;
    end

    if ((state_q == S_WAIT) && conv_valid) begin
      for (int unsigned o = 0; o < OUT_CH; o++) begin
        r = conv_res[o*DATA_W +: DATA_W];
`ifdef CNN_SEQ_RELU_EN
        if (r[DATA_W-1]) r = '0;
`endif
        if ((pool_cnt_q == '0) || ($signed(r) > $signed(max_q[o*DATA_W +: DATA_W]))) begin
          max_d[o*DATA_W +: DATA_W] = r;
        end
      end
      pool_cnt_d = (pool_cnt_q == POOL_LAST_C) ? '0 : pool_cnt_q + 1'b1;
    end

    if ((state_q == S_EMIT) && out_ready) begin
      out_cnt_d = out_cnt_q + 1'b1;
      done_d    = (out_cnt_q == OUT_LAST_C);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= '0;
      max_q      <= '0;
      smp_cnt_q  <= '0;
      pool_cnt_q <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      win_q      <= win_d;
      max_q      <= max_d;
      smp_cnt_q  <= smp_cnt_d;
      pool_cnt_q <= pool_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: a small directed instance and a default-size randomized instance,
// both checked against a sample-level model of conv windows and max-pooling.
module tb_cnn_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- small instance (KSIZE=3, POOL=2, FRAME_LEN=6, PAD_TAIL=2) ----------------
  logic        s_rst, s_start, s_in_valid, s_in_ready, s_cs, s_cv, s_ov, s_or, s_busy, s_done;
  logic        s_spur, s_cv_q;
  logic [7:0]  s_in_data, s_res, s_res_q, s_out;
  logic [23:0] s_win;

  cnn_layer_sequencer #(
    .DATA_W(8), .IN_CH(1), .OUT_CH(1), .KSIZE(3), .POOL(2), .FRAME_LEN(6), .PAD_TAIL(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .start(s_start), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .win_data(s_win), .conv_start(s_cs), .conv_res(s_res),
    .conv_valid(s_cv), .out_data(s_out), .out_valid(s_ov), .out_ready(s_or),
    .busy(s_busy), .done(s_done)
  );

  function automatic logic [7:0] small_sum(input logic [23:0] w);
    int s = 0;
    for (int k = 0; k < 3; k++) s += int'($signed(w[k*8 +: 8]));
    return 8'(s);
  endfunction

  // Tap-sum convolution stub with one cycle of latency; s_spur injects stray results.
  always @(posedge clk) begin
    if (s_rst) s_cv_q <= 1'b0;
    else       s_cv_q <= s_cs;
    if (s_cs) s_res_q <= small_sum(s_win);
  end
  assign s_cv  = s_cv_q | s_spur;
  assign s_res = s_spur ? 8'd100 : s_res_q;

  // ---------------- default instance ----------------
  logic         d_rst, d_start, d_in_valid, d_in_ready, d_cs, d_cv, d_ov, d_or, d_busy, d_done;
  logic [31:0]  d_in_data;
  logic [159:0] d_win;
  logic [63:0]  d_res, d_out;
  logic         d_pend;
  int           d_lat;

  cnn_layer_sequencer u_dflt (
    .clk(clk), .rst(d_rst), .start(d_start), .in_data(d_in_data), .in_valid(d_in_valid),
    .in_ready(d_in_ready), .win_data(d_win), .conv_start(d_cs), .conv_res(d_res),
    .conv_valid(d_cv), .out_data(d_out), .out_valid(d_ov), .out_ready(d_or),
    .busy(d_busy), .done(d_done)
  );

  function automatic int wgt(input int c, input int k, input int o);
    return ((c + 2*k + o) % 3) - 1;
  endfunction

  function automatic logic [63:0] dflt_conv(input logic [159:0] w);
    logic [63:0] r;
    for (int o = 0; o < 8; o++) begin
      int s = 0;
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 5; k++)
          s += wgt(c, k, o) * int'($signed(w[(c*5+k)*8 +: 8]));
      r[o*8 +: 8] = 8'(s);
    end
    return r;
  endfunction

  // Weighted-sum convolution stub with random 2..4 cycle latency.
  always @(posedge clk) begin
    d_cv <= 1'b0;
    if (d_rst) begin
      d_pend <= 1'b0;
    end else if (d_cs) begin
      d_pend <= 1'b1;
      d_lat  <= int'($urandom_range(0, 2));
      d_res  <= dflt_conv(d_win);
    end else if (d_pend) begin
      if (d_lat == 0) begin
        d_cv   <= 1'b1;
        d_pend <= 1'b0;
      end else begin
        d_lat <= d_lat - 1;
      end
    end
  end

  // ---------------- reference models ----------------
  int          sx[8];
  logic [7:0]  s_exp[3];
  int          dx[504][4];
  logic [63:0] d_exp[100];

  function automatic logic signed [7:0] act(input int s);
    logic signed [7:0] t;
    t = 8'(s);
`ifdef CNN_SEQ_RELU_EN
    if (t < 0) t = 8'sd0;
`endif
    return t;
  endfunction

  task automatic build_small(input int first, input int step);
    for (int n = 0; n < 8; n++) sx[n] = (n < 6) ? first + step*n : 0;
    for (int j = 0; j < 3; j++) begin
      logic signed [7:0] mx, t;
      mx = act(sx[2*j] + sx[2*j+1] + sx[2*j+2]);
      t  = act(sx[2*j+1] + sx[2*j+2] + sx[2*j+3]);
      if (t > mx) mx = t;
      s_exp[j] = mx;
    end
  endtask

  function automatic logic [23:0] swin_exp(input int p);
    logic [23:0] w;
    for (int k = 0; k < 3; k++) w[k*8 +: 8] = 8'(sx[p+2-k]);
    return w;
  endfunction

  task automatic build_dflt();
    for (int n = 0; n < 504; n++)
      for (int c = 0; c < 4; c++)
        dx[n][c] = (n < 500) ? int'($urandom_range(0, 255)) - 128 : 0;
    for (int j = 0; j < 100; j++) begin
      for (int o = 0; o < 8; o++) begin
        logic signed [7:0] mx, t;
        mx = 8'sd0;
        for (int p = j*5; p < j*5 + 5; p++) begin
          int s = 0;
          for (int c = 0; c < 4; c++)
            for (int k = 0; k < 5; k++) s += wgt(c, k, o) * dx[p+4-k][c];
          t = act(s);
          if ((p == j*5) || (t > mx)) mx = t;
        end
        d_exp[j][o*8 +: 8] = mx;
      end
    end
  endtask

  function automatic logic [159:0] dwin_exp(input int p);
    logic [159:0] w;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 5; k++) w[(c*5+k)*8 +: 8] = 8'(dx[p+4-k][c]);
    return w;
  endfunction

  function automatic logic [31:0] dsample(input int n);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(dx[n][c]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- small frame runner ----------------
  task automatic run_small(input int stall, input bit disturb);
    int n_in = 0, n_out = 0, n_cs = 0, n_done = 0, stall_c = 0;
    bit finished = 0, pend = 0;
    logic [7:0] prev_out = '0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("s_busy_after_start", s_busy, 1);
    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      if (s_cs) begin
        chk("s_window", s_win, (n_cs < 6) ? swin_exp(n_cs) : 'x);
        n_cs++;
      end
      if (pend) chk("s_out_stable", s_out, prev_out);
      if (s_ov && stall > 0) chk("s_no_in_ready_in_emit", s_in_ready, 0);
      if (s_done) begin
        n_done++;
        finished = 1;
        chk("s_busy_at_done", s_busy, 1);
      end
      if (s_in_ready && n_in < 6) begin
        s_in_data  = 8'(sx[n_in]);
        s_in_valid = 1'b1;
        n_in++;
      end else begin
        s_in_data  = 8'($urandom);
        s_in_valid = 1'b0;
      end
      s_spur  = disturb && s_in_ready && ($urandom_range(0, 1) == 1);
      s_start = disturb && s_busy && !s_done && ($urandom_range(0, 2) == 0);
      if (s_ov) begin
        s_or = (stall_c >= stall);
        stall_c++;
        if (s_or) begin
          chk("s_out_data", s_out, (n_out < 3) ? s_exp[n_out] : 'x);
          n_out++;
          stall_c = 0;
          pend = 0;
        end else begin
          pend = 1;
          prev_out = s_out;
        end
      end else begin
        s_or = (stall == 0);
        pend = 0;
      end
      @(negedge clk);
    end
    s_spur = 1'b0;
    s_start = 1'b0;
    s_in_valid = 1'b0;
    chk("s_finished", finished, 1);
    chk("s_num_out", n_out, 3);
    chk("s_num_conv", n_cs, 6);
    chk("s_num_done", n_done, 1);
    @(negedge clk);
    chk("s_idle_busy", s_busy, 0);
    chk("s_idle_done", s_done, 0);
    chk("s_idle_out_valid", s_ov, 0);
  endtask

  // ---------------- default frame runner; abort_at >= 0 resets during that output's WAIT ----------------
  task automatic run_dflt(input int abort_at);
    int n_in = 0, n_out = 0, n_cs = 0, n_done = 0;
    bit finished = 0, pend = 0, prev_cs = 0;
    logic [63:0] prev_out = '0;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("d_busy_after_start", d_busy, 1);
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (d_cs) begin
        chk("d_window", d_win, (n_cs < 500) ? dwin_exp(n_cs) : 'x);
        n_cs++;
      end
      if (pend) chk("d_out_stable", d_out, prev_out);
      if (d_done) begin
        n_done++;
        finished = 1;
        chk("d_busy_at_done", d_busy, 1);
      end
      if (abort_at >= 0 && prev_cs && n_out == abort_at) begin
        d_rst = 1'b1;
        d_in_valid = 1'b0;
        d_or = 1'b0;
        @(negedge clk);
        chk("d_rst_in_ready", d_in_ready, 0);
        chk("d_rst_win", d_win, 0);
        chk("d_rst_conv_start", d_cs, 0);
        chk("d_rst_out_data", d_out, 0);
        chk("d_rst_out_valid", d_ov, 0);
        chk("d_rst_busy", d_busy, 0);
        chk("d_rst_done", d_done, 0);
        d_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("d_abort_no_done", d_done, 0);
        return;
      end
      prev_cs = d_cs;
      if (d_in_ready && n_in < 500 && $urandom_range(0, 3) != 0) begin
        d_in_data  = dsample(n_in);
        d_in_valid = 1'b1;
        n_in++;
      end else begin
        d_in_data  = $urandom;
        d_in_valid = !d_in_ready && ($urandom_range(0, 1) == 1);
      end
      if (d_ov) begin
        d_or = ($urandom_range(0, 3) != 0);
        if (d_or) begin
          chk("d_out_data", d_out, (n_out < 100) ? d_exp[n_out] : 'x);
          n_out++;
          pend = 0;
        end else begin
          pend = 1;
          prev_out = d_out;
        end
      end else begin
        d_or = ($urandom_range(0, 1) == 1);
        pend = 0;
      end
      @(negedge clk);
    end
    d_in_valid = 1'b0;
    chk("d_finished", finished, 1);
    chk("d_num_out", n_out, 100);
    chk("d_num_conv", n_cs, 500);
    chk("d_num_done", n_done, 1);
    @(negedge clk);
    chk("d_idle_busy", d_busy, 0);
    chk("d_idle_done", d_done, 0);
  endtask

  initial begin
    s_rst = 1'b1; s_start = 1'b0; s_in_data = '0; s_in_valid = 1'b0; s_or = 1'b0; s_spur = 1'b0;
    d_rst = 1'b1; d_start = 1'b0; d_in_data = '0; d_in_valid = 1'b0; d_or = 1'b0;
    repeat (3) @(negedge clk);
    chk("s_reset_in_ready", s_in_ready, 0);
    chk("s_reset_win", s_win, 0);
    chk("s_reset_out_data", s_out, 0);
    chk("s_reset_busy", s_busy, 0);
    chk("d_reset_in_ready", d_in_ready, 0);
    chk("d_reset_conv_start", d_cs, 0);
    chk("d_reset_out_valid", d_ov, 0);
    chk("d_reset_done", d_done, 0);
    s_rst = 1'b0;
    d_rst = 1'b0;
    @(negedge clk);

    build_small(1, 1);
    run_small(0, 1'b0);
    build_small(-1, -1);
    run_small(0, 1'b0);
    build_small(1, 1);
    run_small(10, 1'b0);
    run_small(0, 1'b1);

    build_dflt();
    run_dflt(-1);
    run_dflt(40);
    run_dflt(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
